// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode and mux-select encodings for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXECUTE,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EXEC,
    S_ADDI_WB
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b10;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b01;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_out_t;

  // States that hold a request on the shared memory port until mem_ready.
  function automatic logic is_wait_state(input ctrl_state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory-wait watchdog with sticky mem_err; MEM_TIMEOUT=0 removes it
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting_i,
  output logic mem_err_o
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign mem_err_o = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          err_q, err_d;

      // Leaving the wait (or never waiting) clears the count, so every wait state starts at zero.
      always_comb begin
        cnt_d = '0;
        if (waiting_i) cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CW'(1);
        err_d = err_q | (cnt_d == LIMIT);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          err_q <= err_d;
        end
      end

      assign mem_err_o = err_q;
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM; addi support under MIPS_CTRL_ADDI_EN
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_err
);

  ctrl_state_t state_q, state_d;
  ctrl_out_t   out_c, out_g;
  logic        timer_err;

  always_comb begin
    state_d = state_q;
    out_c   = '0;
    unique case (state_q)
      S_FETCH: begin
        out_c.mem_read  = 1'b1;
        out_c.alu_src_b = ALUSRCB_FOUR;
        out_c.alu_op    = ALU_OP_ADD;
        if (mem_ready) begin
          out_c.ir_write = 1'b1;
          out_c.pc_write = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        out_c.alu_src_b = ALUSRCB_IMM_SH;
        out_c.alu_op    = ALU_OP_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default: begin
            out_c.illegal_op = 1'b1;
            state_d          = S_FETCH;
          end
        endcase
      end
      // opcode is still the IR field here; the IR only reloads in FETCH.
      S_MEM_ADDR: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = ALUSRCB_IMM;
        out_c.alu_op    = ALU_OP_ADD;
        state_d         = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        out_c.mem_read = 1'b1;
        out_c.i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        out_c.reg_write  = 1'b1;
        out_c.mem_to_reg = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WR: begin
        out_c.mem_write = 1'b1;
        out_c.i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = ALUSRCB_B;
        out_c.alu_op    = ALU_OP_FUNCT;
        state_d         = S_R_WB;
      end
      S_R_WB: begin
        out_c.reg_write = 1'b1;
        out_c.reg_dst   = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        out_c.alu_src_a     = 1'b1;
        out_c.alu_src_b     = ALUSRCB_B;
        out_c.alu_op        = ALU_OP_SUB;
        out_c.pc_write_cond = 1'b1;
        out_c.pc_source     = PCSRC_ALUOUT;
        state_d             = S_FETCH;
      end
      S_JUMP: begin
        out_c.pc_write  = 1'b1;
        out_c.pc_source = PCSRC_JUMP;
        state_d         = S_FETCH;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EXEC: begin
        out_c.alu_src_a = 1'b1;
        out_c.alu_src_b = ALUSRCB_IMM;
        out_c.alu_op    = ALU_OP_ADD;
        state_d         = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        out_c.reg_write = 1'b1;
        state_d         = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting_i (is_wait_state(state_q) && !mem_ready),
    .mem_err_o (timer_err)
  );

  assign out_g         = rst ? '0 : out_c;
  assign pc_write      = out_g.pc_write;
  assign pc_write_cond = out_g.pc_write_cond;
  assign i_or_d        = out_g.i_or_d;
  assign mem_read      = out_g.mem_read;
  assign mem_write     = out_g.mem_write;
  assign ir_write      = out_g.ir_write;
  assign mem_to_reg    = out_g.mem_to_reg;
  assign reg_dst       = out_g.reg_dst;
  assign reg_write     = out_g.reg_write;
  assign alu_src_a     = out_g.alu_src_a;
  assign alu_src_b     = out_g.alu_src_b;
  assign alu_op        = out_g.alu_op;
  assign pc_source     = out_g.pc_source;
  assign illegal_op    = out_g.illegal_op;
  assign mem_err       = !rst && timer_err;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_err;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .mem_err       (mem_err)
  );

  logic [16:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [16:0] ov(input logic pw, input logic pwc, input logic iod,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rd, input logic rw,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input logic ill);
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  //                              pw pwc iod mr mw irw m2r rd rw asa asb    aop    psrc   ill
  localparam logic [16:0] E_FETCH  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_DECILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1};
  localparam logic [16:0] E_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMWR  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b00,1'b0};
  localparam logic [16:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_BRANCH = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b01,1'b0};
  localparam logic [16:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Check this cycle's outputs, then move to one time unit after the next rising edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    check(tag, {15'd0, outs}, {15'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {15'd0, outs}, 32'd0);
    check("reset_err", {31'd0, mem_err}, 32'd0);
    rst = 1'b0;

    // R-type
    opcode = 6'b000000;
    cyc("r_fetch", E_FETCH);
    cyc("r_decode", E_DECODE);
    cyc("r_exec", E_EXEC);
    cyc("r_wb", E_RWB);

    // lw with 3 stalled cycles in MEM_RD; mem_ready low during MEM_ADDR is ignored
    opcode = 6'b100011;
    cyc("lw_fetch", E_FETCH);
    cyc("lw_decode", E_DECODE);
    mem_ready = 1'b0;
    cyc("lw_maddr", E_MADDR);
    for (int i = 0; i < 3; i++) cyc($sformatf("lw_rd_wait%0d", i), E_MEMRD);
    mem_ready = 1'b1;
    cyc("lw_rd_done", E_MEMRD);
    cyc("lw_wb", E_MEMWB);

    // sw, no stall
    opcode = 6'b101011;
    cyc("sw_fetch", E_FETCH);
    cyc("sw_decode", E_DECODE);
    cyc("sw_maddr", E_MADDR);
    cyc("sw_wr", E_MEMWR);

    // beq then j
    opcode = 6'b000100;
    cyc("beq_fetch", E_FETCH);
    cyc("beq_decode", E_DECODE);
    cyc("beq_branch", E_BRANCH);
    opcode = 6'b000010;
    cyc("j_fetch", E_FETCH);
    cyc("j_decode", E_DECODE);
    cyc("j_jump", E_JUMP);

    // illegal opcode pulses for exactly one cycle
    opcode = 6'b111111;
    cyc("ill_fetch", E_FETCH);
    cyc("ill_decode", E_DECILL);
    cyc("ill_back_fetch", E_FETCH);
    cyc("ill_decode2", E_DECILL);

    // addi: legal only with the macro
    opcode = 6'b001000;
    cyc("addi_fetch", E_FETCH);
`ifdef MIPS_CTRL_ADDI_EN
    cyc("addi_decode", E_DECODE);
    cyc("addi_exec", E_MADDR);
    cyc("addi_wb", ov(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0));
`else
    cyc("addi_decode_ill", E_DECILL);
`endif

    // watchdog: 4 waiting cycles in FETCH set mem_err, which stays set
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("wd_err_low%0d", i), {31'd0, mem_err}, 32'd0);
      cyc($sformatf("wd_fetch_wait%0d", i), E_FWAIT);
    end
    #1;
    check("wd_err_set", {31'd0, mem_err}, 32'd1);
    mem_ready = 1'b1;
    opcode    = 6'b101011;
    cyc("wd_fetch", E_FETCH);
    check("wd_err_sticky", {31'd0, mem_err}, 32'd1);
    cyc("wd_decode", E_DECODE);
    cyc("wd_maddr", E_MADDR);

    // reset mid MEM_WR
    mem_ready = 1'b0;
    cyc("rst_memwr", E_MEMWR);
    #2;
    rst = 1'b1;
    #1;
    check("rst_outs_zero", {15'd0, outs}, 32'd0);
    check("rst_err_zero", {31'd0, mem_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst_fetch", E_FWAIT);
    check("post_rst_err", {31'd0, mem_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
